// File: rtl/audio_mix_pkg.sv
// Shared types and arithmetic helpers for the audio mixing scheduler.
// Holds the FSM encoding, gain scaling constants and the saturation functions.
package audio_mix_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MAC      = 2'd1,
    S_MASTER_L = 2'd2,
    S_MASTER_R = 2'd3
  } mix_state_e;

  localparam int GAIN_UNITY = 64;
  localparam int GAIN_SHIFT = 6;

  // Full-precision accumulator: sample x unsigned gain, plus growth for summing n sources.
  function automatic int acc_width(input int dw, input int gw, input int n);
    return dw + gw + 1 + $clog2(n);
  endfunction

  function automatic logic signed [16:0] sat17(input logic signed [47:0] v);
    if (v > 48'sd65535)
      return 17'sd65535;
    else if (v < -48'sd65536)
      return -17'sd65536;
    else
      return v[16:0];
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [47:0] v);
    if (v > 48'sd32767)
      return 16'sd32767;
    else if (v < -48'sd32768)
      return -16'sd32768;
    else
      return v[15:0];
  endfunction

  function automatic logic sat16_clips(input logic signed [47:0] v);
    return (v > 48'sd32767) || (v < -48'sd32768);
  endfunction

endpackage

// File: rtl/audio_mul.sv
// Shared signed multiplier, purely combinational.
// Latency: 0 cycles. Backpressure: none, the scheduler owns the operand mux.
// Operands are both signed; unsigned gains are zero-extended by the caller.
module audio_mul #(
  parameter int AW = 17,
  parameter int BW = 8
) (
  input  logic signed [AW-1:0]    a,
  input  logic signed [BW-1:0]    b,
  output logic signed [AW+BW-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/audio_mix_sched.sv
// Sample-rate mixer: snapshots NUM_SRC stereo sources, applies gain/mute/master via one multiplier.
// Latency: out_valid 2*NUM_SRC+3 cycles after an accepted next_sample.
// Backpressure: none; a strobe while busy is dropped and flagged as overrun.
module audio_mix_sched
  import audio_mix_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DW      = 16,
  parameter int GW      = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  next_sample,
  input  logic [NUM_SRC*DW-1:0] src_left,
  input  logic [NUM_SRC*DW-1:0] src_right,
  input  logic [NUM_SRC*GW-1:0] src_gain,
  input  logic [NUM_SRC-1:0]    src_mute,
  input  logic [GW-1:0]         master_gain,
  input  logic                  clip_clr,
  output logic                  busy,
  output logic                  out_valid,
  output logic [DW-1:0]         out_left,
  output logic [DW-1:0]         out_right,
  output logic                  clip_left,
  output logic                  clip_right,
  output logic                  overrun
);

  localparam int ACC_W = acc_width(DW, GW, NUM_SRC);
  localparam int MA_W  = DW + 1;
  localparam int MB_W  = GW + 1;
  localparam int MP_W  = MA_W + MB_W;
  localparam int IDX_W = $clog2(2 * NUM_SRC) + 1;
  localparam int SEL_W = IDX_W - 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * NUM_SRC - 1);

  mix_state_e state;
  logic [IDX_W-1:0] idx;

  logic [NUM_SRC*DW-1:0] snap_left;
  logic [NUM_SRC*DW-1:0] snap_right;
  logic [NUM_SRC*GW-1:0] snap_gain;
  logic [NUM_SRC-1:0]    snap_mute;
  logic [GW-1:0]         snap_master;

  logic signed [ACC_W-1:0] acc_l;
  logic signed [ACC_W-1:0] acc_r;

  logic signed [DW-1:0] pend_left;
  logic                 pend_clip_l;

  logic [SEL_W-1:0]     src_sel;
  logic [DW-1:0]        mac_sample;
  logic [GW-1:0]        mac_gain;
  logic signed [16:0]   s_l;
  logic signed [16:0]   s_r;
  logic signed [MA_W-1:0] mul_a;
  logic signed [MB_W-1:0] mul_b;
  logic signed [MP_W-1:0] mul_p;
  logic signed [47:0]   m_full;
  logic signed [15:0]   m_sat;
  logic                 m_clip;

  assign busy    = (state != S_IDLE);
  assign src_sel = idx[IDX_W-1:1];

  // Step order is L0,R0,L1,R1,...: idx[0] picks the channel, the upper bits the source.
  always_comb begin
    mac_sample = '0;
    mac_gain   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_sel == SEL_W'(i)) begin
        mac_sample = idx[0] ? snap_right[i*DW +: DW] : snap_left[i*DW +: DW];
        mac_gain   = snap_mute[i] ? '0 : snap_gain[i*GW +: GW];
      end
    end
  end

  assign s_l = sat17(48'(acc_l >>> GAIN_SHIFT));
  assign s_r = sat17(48'(acc_r >>> GAIN_SHIFT));

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_MAC: begin
        mul_a = {mac_sample[DW-1], mac_sample};
        mul_b = {1'b0, mac_gain};
      end
      S_MASTER_L: begin
        mul_a = s_l;
        mul_b = {1'b0, snap_master};
      end
      S_MASTER_R: begin
        mul_a = s_r;
        mul_b = {1'b0, snap_master};
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  audio_mul #(
    .AW(MA_W),
    .BW(MB_W)
  ) u_mul (
    .a(mul_a),
    .b(mul_b),
    .p(mul_p)
  );

  assign m_full = 48'(mul_p >>> GAIN_SHIFT);
  assign m_sat  = sat16(m_full);
  assign m_clip = sat16_clips(m_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      snap_left   <= '0;
      snap_right  <= '0;
      snap_gain   <= '0;
      snap_mute   <= '0;
      snap_master <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      pend_left   <= '0;
      pend_clip_l <= 1'b0;
      out_left    <= '0;
      out_right   <= '0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (next_sample) begin
            snap_left   <= src_left;
            snap_right  <= src_right;
            snap_gain   <= src_gain;
            snap_mute   <= src_mute;
            snap_master <= master_gain;
            acc_l       <= '0;
            acc_r       <= '0;
            idx         <= '0;
            state       <= S_MAC;
          end
        end
        S_MAC: begin
          if (idx[0])
            acc_r <= acc_r + ACC_W'(mul_p);
          else
            acc_l <= acc_l + ACC_W'(mul_p);
          if (idx == IDX_LAST)
            state <= S_MASTER_L;
          else
            idx <= idx + IDX_W'(1);
        end
        S_MASTER_L: begin
          pend_left   <= m_sat;
          pend_clip_l <= m_clip;
          state       <= S_MASTER_R;
        end
        S_MASTER_R: begin
          out_left  <= pend_left;
          out_right <= m_sat;
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clip flags land together with the output they describe; a new event beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_left  <= 1'b0;
      clip_right <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (state == S_MASTER_R && pend_clip_l)
        clip_left <= 1'b1;
      else if (clip_clr)
        clip_left <= 1'b0;

      if (state == S_MASTER_R && m_clip)
        clip_right <= 1'b1;
      else if (clip_clr)
        clip_right <= 1'b0;

      if (next_sample && state != S_IDLE)
        overrun <= 1'b1;
      else if (clip_clr)
        overrun <= 1'b0;
    end
  end

endmodule
